// File: rtl/inv_sbox_if.sv
// -----------------------------------------------------------------------------
// inv_sbox_if
// Byte-stream bundle between a producer and the registered AES inverse S-box.
// There is no backpressure, so the bundle carries only valid and data in each
// direction.
//
//   in_valid  producer -> sbox  state carries a valid byte this cycle
//   state     producer -> sbox  input byte ([7:4] table row, [3:0] column)
//   out_valid sbox -> consumer  Sstate carries a valid result
//   Sstate    sbox -> consumer  inverse-substituted byte, one clock after input
//
// Modports:
//   master  producer/consumer side (drives in_valid/state, observes results)
//   slave   inverse S-box side
// -----------------------------------------------------------------------------
interface inv_sbox_if;
    logic       in_valid;
    logic [7:0] state;
    logic       out_valid;
    logic [7:0] Sstate;

    modport master (
        output in_valid,
        output state,
        input  out_valid,
        input  Sstate
    );

    modport slave (
        input  in_valid,
        input  state,
        output out_valid,
        output Sstate
    );
endinterface : inv_sbox_if

// File: rtl/inv_sbox.sv
// -----------------------------------------------------------------------------
// inv_sbox
// Registered AES inverse S-box (InvSubBytes). One byte per clock is looked up
// in the fixed 256-entry FIPS-197 inverse table and registered, with a valid
// flag travelling alongside. Latency is exactly one clock; back-to-back valid
// inputs give back-to-back valid outputs. When in_valid is low the data
// register holds its previous value while out_valid drops.
//
// Ports:
//   clk    in   system clock, all state updates on its rising edge
//   rst_n  in   asynchronous active-low reset; clears Sstate and out_valid
//   bus    slave modport of inv_sbox_if (in_valid, state -> out_valid, Sstate)
// -----------------------------------------------------------------------------
module inv_sbox (
    input  logic        clk,
    input  logic        rst_n,
    inv_sbox_if.slave   bus
);

    logic [7:0] w_inv;
    logic [7:0] r_sstate;
    logic       r_valid;

    // Inverse substitution table, row-major by input byte.
    // NOTE: every one of the 256 codes has an explicit arm, so the case is
    // full and the combinational block cannot infer a latch or emit X.
    always_comb begin
        case (bus.state)
            8'h00: w_inv = 8'h52;
            8'h01: w_inv = 8'h09;
            8'h02: w_inv = 8'h6a;
            8'h03: w_inv = 8'hd5;
            8'h04: w_inv = 8'h30;
            8'h05: w_inv = 8'h36;
            8'h06: w_inv = 8'ha5;
            8'h07: w_inv = 8'h38;
            8'h08: w_inv = 8'hbf;
            8'h09: w_inv = 8'h40;
            8'h0a: w_inv = 8'ha3;
            8'h0b: w_inv = 8'h9e;
            8'h0c: w_inv = 8'h81;
            8'h0d: w_inv = 8'hf3;
            8'h0e: w_inv = 8'hd7;
            8'h0f: w_inv = 8'hfb;
            8'h10: w_inv = 8'h7c;
            8'h11: w_inv = 8'he3;
            8'h12: w_inv = 8'h39;
            8'h13: w_inv = 8'h82;
            8'h14: w_inv = 8'h9b;
            8'h15: w_inv = 8'h2f;
            8'h16: w_inv = 8'hff;
            8'h17: w_inv = 8'h87;
            8'h18: w_inv = 8'h34;
            8'h19: w_inv = 8'h8e;
            8'h1a: w_inv = 8'h43;
            8'h1b: w_inv = 8'h44;
            8'h1c: w_inv = 8'hc4;
            8'h1d: w_inv = 8'hde;
            8'h1e: w_inv = 8'he9;
            8'h1f: w_inv = 8'hcb;
            8'h20: w_inv = 8'h54;
            8'h21: w_inv = 8'h7b;
            8'h22: w_inv = 8'h94;
            8'h23: w_inv = 8'h32;
            8'h24: w_inv = 8'ha6;
            8'h25: w_inv = 8'hc2;
            8'h26: w_inv = 8'h23;
            8'h27: w_inv = 8'h3d;
            8'h28: w_inv = 8'hee;
            8'h29: w_inv = 8'h4c;
            8'h2a: w_inv = 8'h95;
            8'h2b: w_inv = 8'h0b;
            8'h2c: w_inv = 8'h42;
            8'h2d: w_inv = 8'hfa;
            8'h2e: w_inv = 8'hc3;
            8'h2f: w_inv = 8'h4e;
            8'h30: w_inv = 8'h08;
            8'h31: w_inv = 8'h2e;
            8'h32: w_inv = 8'ha1;
            8'h33: w_inv = 8'h66;
            8'h34: w_inv = 8'h28;
            8'h35: w_inv = 8'hd9;
            8'h36: w_inv = 8'h24;
            8'h37: w_inv = 8'hb2;
            8'h38: w_inv = 8'h76;
            8'h39: w_inv = 8'h5b;
            8'h3a: w_inv = 8'ha2;
            8'h3b: w_inv = 8'h49;
            8'h3c: w_inv = 8'h6d;
            8'h3d: w_inv = 8'h8b;
            8'h3e: w_inv = 8'hd1;
            8'h3f: w_inv = 8'h25;
            8'h40: w_inv = 8'h72;
            8'h41: w_inv = 8'hf8;
            8'h42: w_inv = 8'hf6;
            8'h43: w_inv = 8'h64;
            8'h44: w_inv = 8'h86;
            8'h45: w_inv = 8'h68;
            8'h46: w_inv = 8'h98;
            8'h47: w_inv = 8'h16;
            8'h48: w_inv = 8'hd4;
            8'h49: w_inv = 8'ha4;
            8'h4a: w_inv = 8'h5c;
            8'h4b: w_inv = 8'hcc;
            8'h4c: w_inv = 8'h5d;
            8'h4d: w_inv = 8'h65;
            8'h4e: w_inv = 8'hb6;
            8'h4f: w_inv = 8'h92;
            8'h50: w_inv = 8'h6c;
            8'h51: w_inv = 8'h70;
            8'h52: w_inv = 8'h48;
            8'h53: w_inv = 8'h50;
            8'h54: w_inv = 8'hfd;
            8'h55: w_inv = 8'hed;
            8'h56: w_inv = 8'hb9;
            8'h57: w_inv = 8'hda;
            8'h58: w_inv = 8'h5e;
            8'h59: w_inv = 8'h15;
            8'h5a: w_inv = 8'h46;
            8'h5b: w_inv = 8'h57;
            8'h5c: w_inv = 8'ha7;
            8'h5d: w_inv = 8'h8d;
            8'h5e: w_inv = 8'h9d;
            8'h5f: w_inv = 8'h84;
            8'h60: w_inv = 8'h90;
            8'h61: w_inv = 8'hd8;
            8'h62: w_inv = 8'hab;
            8'h63: w_inv = 8'h00;
            8'h64: w_inv = 8'h8c;
            8'h65: w_inv = 8'hbc;
            8'h66: w_inv = 8'hd3;
            8'h67: w_inv = 8'h0a;
            8'h68: w_inv = 8'hf7;
            8'h69: w_inv = 8'he4;
            8'h6a: w_inv = 8'h58;
            8'h6b: w_inv = 8'h05;
            8'h6c: w_inv = 8'hb8;
            8'h6d: w_inv = 8'hb3;
            8'h6e: w_inv = 8'h45;
            8'h6f: w_inv = 8'h06;
            8'h70: w_inv = 8'hd0;
            8'h71: w_inv = 8'h2c;
            8'h72: w_inv = 8'h1e;
            8'h73: w_inv = 8'h8f;
            8'h74: w_inv = 8'hca;
            8'h75: w_inv = 8'h3f;
            8'h76: w_inv = 8'h0f;
            8'h77: w_inv = 8'h02;
            8'h78: w_inv = 8'hc1;
            8'h79: w_inv = 8'haf;
            8'h7a: w_inv = 8'hbd;
            8'h7b: w_inv = 8'h03;
            8'h7c: w_inv = 8'h01;
            8'h7d: w_inv = 8'h13;
            8'h7e: w_inv = 8'h8a;
            8'h7f: w_inv = 8'h6b;
            8'h80: w_inv = 8'h3a;
            8'h81: w_inv = 8'h91;
            8'h82: w_inv = 8'h11;
            8'h83: w_inv = 8'h41;
            8'h84: w_inv = 8'h4f;
            8'h85: w_inv = 8'h67;
            8'h86: w_inv = 8'hdc;
            8'h87: w_inv = 8'hea;
            8'h88: w_inv = 8'h97;
            8'h89: w_inv = 8'hf2;
            8'h8a: w_inv = 8'hcf;
            8'h8b: w_inv = 8'hce;
            8'h8c: w_inv = 8'hf0;
            8'h8d: w_inv = 8'hb4;
            8'h8e: w_inv = 8'he6;
            8'h8f: w_inv = 8'h73;
            8'h90: w_inv = 8'h96;
            8'h91: w_inv = 8'hac;
            8'h92: w_inv = 8'h74;
            8'h93: w_inv = 8'h22;
            8'h94: w_inv = 8'he7;
            8'h95: w_inv = 8'had;
            8'h96: w_inv = 8'h35;
            8'h97: w_inv = 8'h85;
            8'h98: w_inv = 8'he2;
            8'h99: w_inv = 8'hf9;
            8'h9a: w_inv = 8'h37;
            8'h9b: w_inv = 8'he8;
            8'h9c: w_inv = 8'h1c;
            8'h9d: w_inv = 8'h75;
            8'h9e: w_inv = 8'hdf;
            8'h9f: w_inv = 8'h6e;
            8'ha0: w_inv = 8'h47;
            8'ha1: w_inv = 8'hf1;
            8'ha2: w_inv = 8'h1a;
            8'ha3: w_inv = 8'h71;
            8'ha4: w_inv = 8'h1d;
            8'ha5: w_inv = 8'h29;
            8'ha6: w_inv = 8'hc5;
            8'ha7: w_inv = 8'h89;
            8'ha8: w_inv = 8'h6f;
            8'ha9: w_inv = 8'hb7;
            8'haa: w_inv = 8'h62;
            8'hab: w_inv = 8'h0e;
            8'hac: w_inv = 8'haa;
            8'had: w_inv = 8'h18;
            8'hae: w_inv = 8'hbe;
            8'haf: w_inv = 8'h1b;
            8'hb0: w_inv = 8'hfc;
            8'hb1: w_inv = 8'h56;
            8'hb2: w_inv = 8'h3e;
            8'hb3: w_inv = 8'h4b;
            8'hb4: w_inv = 8'hc6;
            8'hb5: w_inv = 8'hd2;
            8'hb6: w_inv = 8'h79;
            8'hb7: w_inv = 8'h20;
            8'hb8: w_inv = 8'h9a;
            8'hb9: w_inv = 8'hdb;
            8'hba: w_inv = 8'hc0;
            8'hbb: w_inv = 8'hfe;
            8'hbc: w_inv = 8'h78;
            8'hbd: w_inv = 8'hcd;
            8'hbe: w_inv = 8'h5a;
            8'hbf: w_inv = 8'hf4;
            8'hc0: w_inv = 8'h1f;
            8'hc1: w_inv = 8'hdd;
            8'hc2: w_inv = 8'ha8;
            8'hc3: w_inv = 8'h33;
            8'hc4: w_inv = 8'h88;
            8'hc5: w_inv = 8'h07;
            8'hc6: w_inv = 8'hc7;
            8'hc7: w_inv = 8'h31;
            8'hc8: w_inv = 8'hb1;
            8'hc9: w_inv = 8'h12;
            8'hca: w_inv = 8'h10;
            8'hcb: w_inv = 8'h59;
            8'hcc: w_inv = 8'h27;
            8'hcd: w_inv = 8'h80;
            8'hce: w_inv = 8'hec;
            8'hcf: w_inv = 8'h5f;
            8'hd0: w_inv = 8'h60;
            8'hd1: w_inv = 8'h51;
            8'hd2: w_inv = 8'h7f;
            8'hd3: w_inv = 8'ha9;
            8'hd4: w_inv = 8'h19;
            8'hd5: w_inv = 8'hb5;
            8'hd6: w_inv = 8'h4a;
            8'hd7: w_inv = 8'h0d;
            8'hd8: w_inv = 8'h2d;
            8'hd9: w_inv = 8'he5;
            8'hda: w_inv = 8'h7a;
            8'hdb: w_inv = 8'h9f;
            8'hdc: w_inv = 8'h93;
            8'hdd: w_inv = 8'hc9;
            8'hde: w_inv = 8'h9c;
            8'hdf: w_inv = 8'hef;
            8'he0: w_inv = 8'ha0;
            8'he1: w_inv = 8'he0;
            8'he2: w_inv = 8'h3b;
            8'he3: w_inv = 8'h4d;
            8'he4: w_inv = 8'hae;
            8'he5: w_inv = 8'h2a;
            8'he6: w_inv = 8'hf5;
            8'he7: w_inv = 8'hb0;
            8'he8: w_inv = 8'hc8;
            8'he9: w_inv = 8'heb;
            8'hea: w_inv = 8'hbb;
            8'heb: w_inv = 8'h3c;
            8'hec: w_inv = 8'h83;
            8'hed: w_inv = 8'h53;
            8'hee: w_inv = 8'h99;
            8'hef: w_inv = 8'h61;
            8'hf0: w_inv = 8'h17;
            8'hf1: w_inv = 8'h2b;
            8'hf2: w_inv = 8'h04;
            8'hf3: w_inv = 8'h7e;
            8'hf4: w_inv = 8'hba;
            8'hf5: w_inv = 8'h77;
            8'hf6: w_inv = 8'hd6;
            8'hf7: w_inv = 8'h26;
            8'hf8: w_inv = 8'he1;
            8'hf9: w_inv = 8'h69;
            8'hfa: w_inv = 8'h14;
            8'hfb: w_inv = 8'h63;
            8'hfc: w_inv = 8'h55;
            8'hfd: w_inv = 8'h21;
            8'hfe: w_inv = 8'h0c;
            8'hff: w_inv = 8'h7d;
        endcase
    end

    // Output stage. The data register only loads on a valid cycle so the last
    // result stays visible through idle cycles; the valid flag simply follows
    // in_valid with one clock of delay.
    // NOTE: both registers sit on the asynchronous reset so a mid-stream reset
    // discards the in-flight byte at once; the table itself is pure logic and
    // needs no reset.
    // NOTE: non-blocking assignments keep the registers updating together on
    // the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_sstate <= 8'h00;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_sstate <= w_inv;
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.Sstate    = r_sstate;

endmodule : inv_sbox

// File: tb/tb_inv_sbox.sv
// -----------------------------------------------------------------------------
// tb_inv_sbox
// Self-checking bench for inv_sbox. The reference inverse table is derived
// from first principles: the forward AES S-box is computed as the GF(2^8)
// multiplicative inverse followed by the affine transform, and the inverse
// table is obtained by inverting that permutation.
// -----------------------------------------------------------------------------
module tb_inv_sbox;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    inv_sbox_if bus_if();

    inv_sbox u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] g;
        for (int i = 0; i < 256; i++) begin
            x = 8'(i);
            g = 8'h00;
            if (x != 8'h00) begin
                for (int j = 1; j < 256; j++) begin
                    y = 8'(j);
                    if (gf_mul(x, y) == 8'h01) g = y;
                end
            end
            fwd_tab[i] = g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
        end
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    endtask

    // Drive one input beat at the falling edge and return 1ns after the next
    // rising edge, where the registered result for that beat is visible.
    task automatic drive(input logic v, input logic [7:0] s);
        @(negedge clk);
        bus_if.in_valid = v;
        bus_if.state    = s;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", bus_if.out_valid);
        end
        checks++;
        if (bus_if.Sstate !== 8'h00) begin
            errors++;
            $display("FAIL reset_sstate: got %h expected 00", bus_if.Sstate);
        end
        @(negedge clk);
        rst_n = 1'b1;

        drive(1'b1, 8'h04);
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.Sstate !== 8'h30) begin
            errors++;
            $display("FAIL reset_prior: got v=%b %h expected v=1 30", bus_if.out_valid, bus_if.Sstate);
        end

        // Asynchronous assertion mid-cycle, with a valid byte still presented.
        bus_if.state = 8'h46;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.Sstate !== 8'h00) begin
            errors++;
            $display("FAIL reset_async: got v=%b %h expected v=0 00", bus_if.out_valid, bus_if.Sstate);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.Sstate !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got v=%b %h expected v=0 00", bus_if.out_valid, bus_if.Sstate);
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.Sstate !== 8'h00) begin
            errors++;
            $display("FAIL reset_release: got v=%b %h expected v=0 00", bus_if.out_valid, bus_if.Sstate);
        end
        drive(1'b1, 8'h46);
        checks++;
        if (bus_if.out_valid !== 1'b1 || bus_if.Sstate !== 8'h98) begin
            errors++;
            $display("FAIL reset_first: got v=%b %h expected v=1 98", bus_if.out_valid, bus_if.Sstate);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ins  [3];
        logic [7:0] outs [3];
        ins  = '{8'h04, 8'h46, 8'hdf};
        outs = '{8'h30, 8'h98, 8'hef};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ins[i]);
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.Sstate !== outs[i]) begin
                errors++;
                $display("FAIL directed_%h: got v=%b %h expected v=1 %h",
                         ins[i], bus_if.out_valid, bus_if.Sstate, outs[i]);
            end
        end
    endtask

    task automatic test_corners();
        logic [7:0] ins  [6];
        logic [7:0] outs [6];
        ins  = '{8'h00, 8'h63, 8'hff, 8'h16, 8'h7c, 8'h52};
        outs = '{8'h52, 8'h00, 8'h7d, 8'hff, 8'h01, 8'h48};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, ins[i]);
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.Sstate !== outs[i]) begin
                errors++;
                $display("FAIL corner_%h: got v=%b %h expected v=1 %h",
                         ins[i], bus_if.out_valid, bus_if.Sstate, outs[i]);
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 8'h04);
        checks++;
        if (bus_if.Sstate !== 8'h30) begin
            errors++;
            $display("FAIL hold_load: got %h expected 30", bus_if.Sstate);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'hff);
            checks++;
            if (bus_if.out_valid !== 1'b0 || bus_if.Sstate !== 8'h30) begin
                errors++;
                $display("FAIL hold_%0d: got v=%b %h expected v=0 30", i, bus_if.out_valid, bus_if.Sstate);
            end
        end
    endtask

    task automatic test_exhaustive();
        int pulses;
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 8'(i));
            if (bus_if.out_valid === 1'b1) pulses++;
            checks++;
            if (bus_if.Sstate !== inv_tab[i]) begin
                errors++;
                $display("FAIL sweep_%h: got %h expected %h", 8'(i), bus_if.Sstate, inv_tab[i]);
            end
        end
        checks++;
        if (pulses != 256) begin
            errors++;
            $display("FAIL sweep_pulses: got %0d expected 256", pulses);
        end
        // Round trip through the forward box: InvSbox(Sbox(x)) must give x back.
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, fwd_tab[i]);
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.Sstate !== 8'(i)) begin
                errors++;
                $display("FAIL bijection_%h: got v=%b %h expected v=1 %h",
                         8'(i), bus_if.out_valid, bus_if.Sstate, 8'(i));
            end
        end
    endtask

    task automatic test_random();
        logic       v;
        logic [7:0] s;
        logic [7:0] m_s;
        drive(1'b1, 8'h00);
        m_s = inv_tab[0];
        for (int i = 0; i < 300; i++) begin
            v = ($urandom_range(0, 3) != 0);
            s = 8'($urandom_range(0, 255));
            drive(v, s);
            if (v) m_s = inv_tab[s];
            checks++;
            if (bus_if.out_valid !== v || bus_if.Sstate !== m_s) begin
                errors++;
                $display("FAIL random_%0d: in v=%b %h got v=%b %h expected v=%b %h",
                         i, v, s, bus_if.out_valid, bus_if.Sstate, v, m_s);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0] s;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                #1;
                bus_if.in_valid = 1'b0;
                rst_n = 1'b0;
                #1;
                checks++;
                if (bus_if.out_valid !== 1'b0 || bus_if.Sstate !== 8'h00) begin
                    errors++;
                    $display("FAIL midrst_during: got v=%b %h expected v=0 00", bus_if.out_valid, bus_if.Sstate);
                end
                #4;
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                checks++;
                if (bus_if.out_valid !== 1'b0 || bus_if.Sstate !== 8'h00) begin
                    errors++;
                    $display("FAIL midrst_after: got v=%b %h expected v=0 00", bus_if.out_valid, bus_if.Sstate);
                end
            end
            s = 8'($urandom_range(0, 255));
            drive(1'b1, s);
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.Sstate !== inv_tab[s]) begin
                errors++;
                $display("FAIL midrst_byte%0d: in %h got v=%b %h expected v=1 %h",
                         i, s, bus_if.out_valid, bus_if.Sstate, inv_tab[s]);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.state    = 8'h00;
        build_tables();

        test_reset();
        test_directed();
        test_corners();
        test_hold();
        test_exhaustive();
        test_random();
        test_reset_midstream();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_inv_sbox

// File: doc/inv_sbox.md
Name: inv_sbox

Overview:
Registered AES inverse S-box (InvSubBytes byte substitution, FIPS-197 Fig. 14). It maps one 8-bit state byte per clock to its inverse-substituted value. The decryption datapath instantiates it per byte lane of the inverse round. Output is registered, with a valid flag travelling alongside the data.

Parameters:
None. The 256-entry table is fixed by FIPS-197 and is not configurable.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  state is a valid byte this cycle
state  input  8  input byte, bits [7:4] = table row, bits [3:0] = table column
out_valid  output  1  Sstate holds a valid result
Sstate  output  8  inverse S-box of the byte captured on the previous valid cycle

Behaviour:
- Reset:
  - rst_n low immediately forces Sstate = 8'h00 and out_valid = 0, with no clock required.
  - Both are held there while rst_n is low.
  - Release is synchronous in effect: the first capture happens on the first rising clk edge with rst_n high.
- Lookup:
  - Combinational inverse S-box of state, full 256-entry FIPS-197 inverse table, implemented as a case/ROM.
  - No GF(2^8) arithmetic is required; the table alone defines the function.
  - Every input code 00..FF has a defined entry; there is no default or X output.
- Latency and valid:
  - Exactly 1 clock.
  - On each rising clk edge with rst_n high: out_valid <= in_valid.
  - If in_valid = 1: Sstate <= InvSbox(state).
  - If in_valid = 0: Sstate holds its previous value.
- Throughput: one byte per clock. Back-to-back valid inputs give back-to-back valid outputs with no bubble.
- No backpressure: there is no ready signal, and the consumer must accept out_valid whenever it is asserted.
- Reset mid-stream: any in-flight byte is discarded, and out_valid is 0 on the first cycle after reset release.
- Bijection property: InvSbox(Sbox(x)) = x for all 256 x. The table must be exactly the inverse of the forward S-box used elsewhere in the design.
- Fixed reference points (the verifier checks these):
  - 00->52, 04->30, 46->98
  - 63->00, 7C->01, DF->EF
  - FF->7D, 16->FF, 52->48

Test Plan:
1. Reset: assert rst_n=0 asynchronously mid-cycle with prior Sstate=30 -> Sstate=00 and out_valid=0 immediately; both stay there until release; the first post-release valid input appears one clock later.
2. Directed vectors: in_valid=1 with state=04, then 46, then DF on successive cycles -> one clock later each, Sstate=30, 98, EF with out_valid=1 each cycle and no gaps.
3. Corners: state=00, 63, FF, 16 -> Sstate=52, 00, 7D, FF respectively.
4. Hold: after state=04 is captured (Sstate=30), drive in_valid=0 with state=FF for 3 cycles -> Sstate stays 30 and out_valid=0.
5. Exhaustive: sweep state 00..FF with in_valid=1 continuously -> each output matches the FIPS-197 inverse table, 1-cycle latency, 256 consecutive out_valid pulses. Also apply the forward S-box reference model and check InvSbox(Sbox(x)) = x for all x.
6. Reset mid-stream: stream 10 valid bytes and pulse rst_n low for half a cycle at byte 5 -> outputs before the pulse are correct, out_valid=0 and Sstate=00 during and immediately after the pulse, and subsequent bytes are correct again.
